// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns ceil(log2(n)), but never less than 1 so a single-step counter still has a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// Start/done handshake and operand/result bus of the digit-serial adder.
interface serial_digit_adder_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic             i_sub;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_s;
  logic             o_cout;
  logic             o_v;

  modport master (
    output i_start, i_sub, i_a, i_b, i_cin,
    input  o_busy, o_done, o_s, o_cout, o_v
  );

  modport slave (
    input  i_start, i_sub, i_a, i_b, i_cin,
    output o_busy, o_done, o_s, o_cout, o_v
  );
endinterface

// File: rtl/serial_digit_adder_digit.sv
// Combinational ripple chain of DIGIT full-adder cells; also exposes the carry into the top bit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout  = w_c[DIGIT];
  assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// WIDTH-bit adder/subtractor processing DIGIT bits per clock, LSB digit first.
// State table:  IDLE | waiting for start;  RUN | one digit per edge;  DONE | done pulse, results valid.
module serial_digit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  serial_digit_adder_if.slave  io_bus
);

  localparam int STEPS  = WIDTH / DIGIT;
  localparam int STEP_W = clog2_min1(STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_e            r_state;
  logic [STEP_W-1:0] r_step;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_s;
  logic              r_carry;
  logic              r_busy;
  logic              r_done;
  logic              r_cout;
  logic              r_v;

  logic [31:0]       w_base;
  logic [WIDTH-1:0]  w_a_shift;
  logic [WIDTH-1:0]  w_b_shift;
  logic [DIGIT-1:0]  w_sum;
  logic              w_cout;
  logic              w_c_msb;

  // Operands stay latched; the current digit is selected by shifting it down to bit 0.
  assign w_base    = 32'(r_step) * 32'(DIGIT);
  assign w_a_shift = r_a >> w_base;
  assign w_b_shift = r_b >> w_base;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a     (w_a_shift[DIGIT-1:0]),
    .i_b     (w_b_shift[DIGIT-1:0]),
    .i_cin   (r_carry),
    .o_sum   (w_sum),
    .o_cout  (w_cout),
    .o_c_msb (w_c_msb)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (io_bus.i_start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_a     <= io_bus.i_a;
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            r_b     <= io_bus.i_sub ? ~io_bus.i_b : io_bus.i_b;
            r_carry <= io_bus.i_sub | io_bus.i_cin;
            r_step  <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          // S was cleared on accept and each digit is written once, so OR-in is a plain write.
          r_s     <= r_s | (WIDTH'(w_sum) << w_base);
          r_carry <= w_cout;
          if (r_step == LAST_STEP) begin
            r_cout  <= w_cout;
            r_v     <= w_c_msb ^ w_cout;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.o_busy = r_busy;
  assign io_bus.o_done = r_done;
  assign io_bus.o_s    = r_s;
  assign io_bus.o_cout = r_cout;
  assign io_bus.o_v    = r_v;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench for serial_digit_adder: directed, random, protocol and reset scenarios.
module tb_serial_digit_adder;
  import adder_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_digit_adder_if #(.WIDTH(W)) bus  ();
  serial_digit_adder_if #(.WIDTH(W)) bus1 ();

  serial_digit_adder #(.WIDTH(W), .DIGIT(4)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  serial_digit_adder #(.WIDTH(W), .DIGIT(W)) dut1 (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus1)
  );

  // Reference: signed/unsigned integer arithmetic, no digit-level detail.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input bit sub,
                                input bit cin, output logic [15:0] s, output bit cout, output bit v);
    int ua, ub, sa, sb, ur, sr;
    ua = {16'b0, a};
    ub = {16'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      ur   = ua - ub;
      sr   = sa - sb;
      cout = (ua >= ub);
    end else begin
      ur   = ua + ub + int'(cin);
      sr   = sa + sb + int'(cin);
      cout = (ur > 65535);
    end
    s = ur[15:0];
    v = (sr > 32767) || (sr < -32768);
  endfunction

  // Drives one operation on the DIGIT=4 instance and records what it observed.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit sub, input bit cin,
                       output logic [15:0] s, output bit cout, output bit v,
                       output int lat, output int busy_n, output int done_n);
    @(negedge clk);
    bus.i_a = a; bus.i_b = b; bus.i_sub = sub; bus.i_cin = cin; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat = -1; busy_n = 0; done_n = 0; s = '0; cout = 1'b0; v = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.o_busy) busy_n++;
      if (bus.o_done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; s = bus.o_s; cout = bus.o_cout; v = bus.o_v;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.i_start = 1'b1; bus.i_sub = 1'b0; bus.i_a = 16'h1234; bus.i_b = 16'h1111; bus.i_cin = 1'b0;
    bus1.i_start = 1'b0; bus1.i_sub = 1'b0; bus1.i_a = '0; bus1.i_b = '0; bus1.i_cin = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++; $display("FAIL reset_hs: busy=%b done=%b required 0 0", bus.o_busy, bus.o_done);
    end
    checks++;
    if (bus.o_s !== 16'h0 || bus.o_cout !== 1'b0 || bus.o_v !== 1'b0) begin
      errors++; $display("FAIL reset_out: S=%h Cout=%b V=%b required 0000 0 0", bus.o_s, bus.o_cout, bus.o_v);
    end
    bus.i_start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h00FF};
    logic [15:0] tb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
    bit          tsub [6] = '{0, 0, 0, 1, 1, 0};
    bit          tcin [6] = '{0, 0, 0, 0, 0, 1};
    logic [15:0] ts [6] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0100};
    bit          tco  [6] = '{0, 1, 0, 0, 1, 0};
    bit          tv   [6] = '{0, 0, 1, 0, 1, 0};
    logic [15:0] s;
    bit cout, v;
    int lat, busy_n, done_n;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], tsub[i], tcin[i], s, cout, v, lat, busy_n, done_n);
      checks++;
      if (s !== ts[i] || cout !== tco[i] || v !== tv[i]) begin
        errors++;
        $display("FAIL directed_%0d: S=%h Cout=%b V=%b required S=%h Cout=%b V=%b",
                 i, s, cout, v, ts[i], tco[i], tv[i]);
      end
      checks++;
      if (lat !== 4 || busy_n !== 4 || done_n !== 1) begin
        errors++;
        $display("FAIL directed_timing_%0d: latency=%0d busy_cycles=%0d done_pulses=%0d required 4 4 1",
                 i, lat, busy_n, done_n);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b, s, es;
    bit sub, cin, cout, v, ec, ev;
    int lat, busy_n, done_n;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom_range(1)); cin = 1'($urandom_range(1));
      if (i < 4) begin a = 16'h8000 | a; b = (i < 2) ? (16'h8000 | b) : (b & 16'h7FFF); end
      model(a, b, sub, cin, es, ec, ev);
      do_op(a, b, sub, cin, s, cout, v, lat, busy_n, done_n);
      checks++;
      if (s !== es || cout !== ec || v !== ev || lat !== 4) begin
        errors++;
        $display("FAIL random_%0d (A=%h B=%h sub=%b cin=%b): S=%h Cout=%b V=%b lat=%0d required S=%h Cout=%b V=%b lat=4",
                 i, a, b, sub, cin, s, cout, v, lat, es, ec, ev);
      end
    end
  endtask

  task automatic test_start_during_run;
    logic [15:0] s;
    int d, done_n;
    @(negedge clk);
    bus.i_a = 16'h1111; bus.i_b = 16'h2222; bus.i_sub = 1'b0; bus.i_cin = 1'b0; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    bus.i_a = 16'hAAAA; bus.i_b = 16'h5555; bus.i_sub = 1'b1; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    d = -1; done_n = 0; s = '0;
    for (int k = 2; k < 14; k++) begin
      if (bus.o_done) begin
        done_n++;
        if (d < 0) begin d = k; s = bus.o_s; end
      end
      @(negedge clk);
    end
    checks++;
    if (s !== 16'h3333 || d !== 4 || done_n !== 1) begin
      errors++;
      $display("FAIL start_in_run: S=%h done_at=%0d pulses=%0d required S=3333 done_at=4 pulses=1", s, d, done_n);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s1, s2;
    bit c2;
    int d1, d2;
    @(negedge clk);
    bus.i_a = 16'h0F0F; bus.i_b = 16'h0101; bus.i_sub = 1'b0; bus.i_cin = 1'b0; bus.i_start = 1'b1;
    @(negedge clk);
    d1 = -1; d2 = -1; s1 = '0; s2 = '0; c2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (bus.o_done) begin
        if (d1 < 0) begin
          d1 = k; s1 = bus.o_s;
          bus.i_a = 16'h1000; bus.i_b = 16'h0001; bus.i_sub = 1'b1;
        end else if (d2 < 0) begin
          d2 = k; s2 = bus.o_s; c2 = bus.o_cout;
        end
      end else if (d1 >= 0) begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    checks++;
    if (d1 !== 4 || d2 - d1 !== 5) begin
      errors++;
      $display("FAIL b2b_timing: first_done=%0d second_done=%0d required 4 and 9", d1, d2);
    end
    checks++;
    if (s1 !== 16'h1010 || s2 !== 16'h0FFF || c2 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_results: S1=%h S2=%h Cout2=%b required 1010 0FFF 1", s1, s2, c2);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] s;
    bit cout, v;
    int lat, busy_n, done_n, seen;
    @(negedge clk);
    bus.i_a = 16'hFFFF; bus.i_b = 16'hFFFF; bus.i_sub = 1'b0; bus.i_cin = 1'b0; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_s !== 16'h0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b S=%h done=%b required 0 0000 0", bus.o_busy, bus.o_s, bus.o_done);
    end
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.o_done || bus.o_busy) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_no_done: busy/done cycles=%0d required 0", seen);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, cout, v, lat, busy_n, done_n);
    checks++;
    if (s !== 16'h0002 || cout !== 1'b0 || v !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL after_reset_add: S=%h Cout=%b V=%b lat=%0d required 0002 0 0 4", s, cout, v, lat);
    end
  endtask

  task automatic test_single_digit;
    logic [15:0] a, b, es;
    bit sub, cin, ec, ev;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom_range(1)); cin = 1'($urandom_range(1));
      if (i == 0) begin a = 16'h7FFF; b = 16'h0001; sub = 1'b0; cin = 1'b0; end
      model(a, b, sub, cin, es, ec, ev);
      @(negedge clk);
      bus1.i_a = a; bus1.i_b = b; bus1.i_sub = sub; bus1.i_cin = cin; bus1.i_start = 1'b1;
      @(negedge clk);
      bus1.i_start = 1'b0;
      checks++;
      if (bus1.o_busy !== 1'b1 || bus1.o_done !== 1'b0) begin
        errors++;
        $display("FAIL single_digit_run_%0d: busy=%b done=%b required 1 0", i, bus1.o_busy, bus1.o_done);
      end
      @(negedge clk);
      checks++;
      if (bus1.o_done !== 1'b1 || bus1.o_s !== es || bus1.o_cout !== ec || bus1.o_v !== ev) begin
        errors++;
        $display("FAIL single_digit_%0d: done=%b S=%h Cout=%b V=%b required 1 %h %b %b",
                 i, bus1.o_done, bus1.o_s, bus1.o_cout, bus1.o_v, es, ec, ev);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_start_during_run;
    test_back_to_back;
    test_reset_mid_run;
    test_single_digit;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

Multi-cycle, parametrised WIDTH-bit adder/subtractor that processes operands DIGIT bits per clock, least-significant digit first, holding the inter-digit carry in a register. It is the sequential, width-generic successor to the single-bit full-adder cell. It serves datapaths that trade latency for area and need wide add/sub with carry-out and signed-overflow flags behind a start/done handshake.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per clock; 1 ≤ DIGIT ≤ WIDTH.
- Derived: STEPS = WIDTH/DIGIT; step counter width = clog2(STEPS), minimum 1.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- sub  in  1  0: S = A + B + Cin; 1: S = A − B, which is A + ~B + 1. Cin is ignored when sub=1.
- A  in  WIDTH  operand A, latched on accept.
- B  in  WIDTH  operand B, latched on accept.
- Cin  in  1  carry-in for add, latched on accept.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; S/Cout/V valid.
- S  out  WIDTH  result register.
- Cout  out  1  carry out of the MSB. For sub, 1 means no borrow.
- V  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 → RUN. On this accept edge:
  - Latch A. Latch B, or ~B when sub=1.
  - Carry register ← Cin for add, 1 for sub.
  - Step ← 0; clear S, Cout and V.
- IDLE or DONE with start=0: IDLE stays IDLE; DONE → IDLE.
- RUN, each edge: add digit[step] of the latched operands plus the carry register.
  - Write the sum into S[step*DIGIT +: DIGIT].
  - Carry register ← digit carry-out; step increments.
- RUN on the edge where step = STEPS−1: the final digit is written as above, then:
  - Cout ← MSB carry-out.
  - V ← carry into MSB XOR MSB carry-out.
  - State → DONE.
- start is ignored while in RUN; busy=1 tells the master so.
- Intermediate S contents during RUN are not valid. S, Cout and V are valid from done until the next accept.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset values: state IDLE, busy 0, done 0, S 0, Cout 0, V 0, carry 0, step 0.
- Reset takes priority over every other event, including start.
- Reset mid-RUN abandons the operation with no done pulse.

## Timing
- Call the accept edge E0.
- Edges E1..E_STEPS each process one digit.
- busy is high in the cycles from after E0 until E_STEPS.
- done is high for exactly the one cycle following E_STEPS.
- Latency from accept edge to done: STEPS cycles.
- Back-to-back: start held high during the DONE cycle is accepted at the next edge, giving throughput of one operation per STEPS+1 cycles.
- DIGIT = WIDTH: single RUN cycle; done follows one cycle after accept.
- Outputs are registered only. There is no combinational path from any input to any output.

## Structure
- Shared package adder_pkg holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - A clog2 helper function for the step counter width.
- Sub-module digit_adder, parametrised by DIGIT: a combinational ripple chain of full-adder cells.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (the carry into its top bit, used for V).
- The top level contains the FSM, step counter, operand/carry registers and the result register.

## Test plan
All cases use WIDTH=16, DIGIT=4.
- Add: A=0x1234, B=0x4321, Cin=0 → S=0x5555, Cout=0, V=0. busy is high for 4 cycles; done pulses once, 4 cycles after accept.
- Carry ripple across all digits: A=0xFFFF, B=0x0001, Cin=0 → S=0x0000, Cout=1, V=0.
- Signed overflow: A=0x7FFF, B=0x0001 → S=0x8000, V=1, Cout=0.
- Subtract:
  - sub=1, A=0x0005, B=0x0007 → S=0xFFFE, Cout=0, V=0.
  - sub=1, A=0x8000, B=0x0001 → S=0x7FFF, Cout=1, V=1.
- Protocol:
  - start pulsed during RUN with new operands → ignored; the original result is delivered.
  - start held through DONE → second operation accepted immediately; done pulses 5 cycles apart.
- Reset during the 2nd RUN cycle → next cycle shows busy=0, S=0, no done pulse. A subsequent add of 0x0001+0x0001 yields 0x0002.
